// File: rtl/snake_input_ctrl.sv
// Keypad-to-snake command sequencer: debounce, key map, reversal filter,
// two-deep turn queue drained one entry per game tick.
module snake_input_ctrl #(
    parameter int         PRESS_CYCLES   = 500000,
    parameter int         RELEASE_CYCLES = 2500000,
    parameter logic [1:0] INIT_DIR       = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_val,
    input  logic       key_pressed,
    input  logic       tick,
    output logic [1:0] dir,
    output logic       dir_update,
    output logic       paused,
    output logic       restart,
    output logic [1:0] q_count,
    output logic       drop
);

    localparam int PW = $clog2(PRESS_CYCLES + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [PW-1:0] P_MAX = PW'(PRESS_CYCLES);
    localparam logic [RW-1:0] R_MAX = RW'(RELEASE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIRM,
        S_HELD
    } st_t;

    st_t           state;
    st_t           state_n;
    logic [3:0]    latched;
    logic [PW-1:0] press_cnt;
    logic [RW-1:0] rel_cnt;
    logic          accept;

    logic          dir_ev;
    logic [1:0]    ev_dir;
    logic          pause_ev;
    logic          restart_ev;

    logic [1:0]    q_head;
    logic [1:0]    q_tail;
    logic          pop;
    logic          push;
    logic          drop_c;
    logic [1:0]    cnt_p;
    logic [1:0]    dir_n;
    logic [1:0]    head_p;
    logic [1:0]    ref_dir;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (key_pressed) state_n = S_CONFIRM;
            end
            S_CONFIRM: begin
                if (press_cnt == P_MAX)    state_n = S_HELD;
                else if (rel_cnt == R_MAX) state_n = S_IDLE;
            end
            S_HELD: begin
                if (rel_cnt == R_MAX) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        accept = (state == S_CONFIRM) && (press_cnt == P_MAX);
    end

    // Dropouts of key_pressed only age rel_cnt; press progress is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            latched   <= '0;
            press_cnt <= '0;
            rel_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rel_cnt <= '0;
                    if (key_pressed) begin
                        latched   <= key_val;
                        press_cnt <= PW'(1);
                    end else begin
                        press_cnt <= '0;
                    end
                end
                S_CONFIRM: begin
                    if (key_pressed) begin
                        rel_cnt <= '0;
                        if (key_val == latched) begin
                            if (press_cnt != P_MAX)
                                press_cnt <= press_cnt + PW'(1);
                        end else begin
                            latched   <= key_val;
                            press_cnt <= PW'(1);
                        end
                    end else if (rel_cnt != R_MAX) begin
                        rel_cnt <= rel_cnt + RW'(1);
                    end
                end
                S_HELD: begin
                    if (key_pressed)
                        rel_cnt <= '0;
                    else if (rel_cnt != R_MAX)
                        rel_cnt <= rel_cnt + RW'(1);
                end
                default: begin
                    press_cnt <= '0;
                    rel_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        dir_ev     = 1'b0;
        ev_dir     = 2'b00;
        pause_ev   = 1'b0;
        restart_ev = 1'b0;
        if (accept) begin
            unique case (1'b1)
                (latched == 4'h2): begin dir_ev = 1'b1; ev_dir = 2'b00; end
                (latched == 4'h8): begin dir_ev = 1'b1; ev_dir = 2'b01; end
                (latched == 4'h4): begin dir_ev = 1'b1; ev_dir = 2'b10; end
                (latched == 4'h6): begin dir_ev = 1'b1; ev_dir = 2'b11; end
                (latched == 4'h5): pause_ev   = 1'b1;
                (latched == 4'hF): restart_ev = 1'b1;
                default: ;
            endcase
        end
    end

    // Pop is resolved first so a push sees the post-pop tail.
    always_comb begin
        pop    = tick && !paused && (q_count != 2'd0) && !restart_ev;
        cnt_p  = q_count - {1'b0, pop};
        dir_n  = pop ? q_head : dir;
        head_p = pop ? q_tail : q_head;
        if (cnt_p == 2'd0)      ref_dir = dir_n;
        else if (cnt_p == 2'd1) ref_dir = head_p;
        else                    ref_dir = q_tail;
        push   = dir_ev && (ev_dir != ref_dir) &&
                 (ev_dir != (ref_dir ^ 2'b01)) && (cnt_p != 2'd2);
        drop_c = dir_ev && !push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir        <= INIT_DIR;
            paused     <= 1'b0;
            q_count    <= 2'd0;
            q_head     <= 2'b00;
            q_tail     <= 2'b00;
            dir_update <= 1'b0;
            restart    <= 1'b0;
            drop       <= 1'b0;
        end else begin
            dir_update <= pop;
            restart    <= restart_ev;
            drop       <= drop_c;
            if (restart_ev) begin
                q_count <= 2'd0;
                dir     <= INIT_DIR;
                paused  <= 1'b0;
            end else begin
                dir     <= dir_n;
                q_head  <= head_p;
                q_count <= cnt_p + {1'b0, push};
                if (push) begin
                    if (cnt_p == 2'd0) q_head <= ev_dir;
                    else               q_tail <= ev_dir;
                end
                if (pause_ev) paused <= ~paused;
            end
        end
    end

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with short debounce limits.
module tb_snake_input_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] key_val;
    logic       key_pressed;
    logic       tick;
    logic [1:0] dir;
    logic       dir_update;
    logic       paused;
    logic       restart;
    logic [1:0] q_count;
    logic       drop;

    int n_checks = 0;
    int n_errors = 0;
    int n_drop   = 0;
    int n_rst    = 0;
    int n_upd    = 0;

    snake_input_ctrl #(
        .PRESS_CYCLES  (4),
        .RELEASE_CYCLES(8),
        .INIT_DIR      (2'b11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_val    (key_val),
        .key_pressed(key_pressed),
        .tick       (tick),
        .dir        (dir),
        .dir_update (dir_update),
        .paused     (paused),
        .restart    (restart),
        .q_count    (q_count),
        .drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drop)       n_drop++;
        if (restart)    n_rst++;
        if (dir_update) n_upd++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold,
                         input int tick_at);
        @(negedge clk);
        key_val     = k;
        key_pressed = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            tick = (i == tick_at);
        end
        tick        = 1'b0;
        key_pressed = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_tick(input string tag, input int upd,
                           input int exp_dir, input int exp_q);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check({tag, "_upd"}, dir_update, upd);
        check({tag, "_dir"}, dir, exp_dir);
        check({tag, "_q"}, q_count, exp_q);
        @(negedge clk);
        check({tag, "_upd_off"}, dir_update, 0);
    endtask

    initial begin
        rst         = 1'b1;
        key_val     = 4'h0;
        key_pressed = 1'b0;
        tick        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dir", dir, 3);
        check("rst_paused", paused, 0);
        check("rst_q", q_count, 0);
        check("rst_pulses", {dir_update, restart, drop}, 0);

        // bouncing key 6 while already heading right
        @(negedge clk);
        key_val = 4'h6;
        for (int i = 0; i < 40; i++) begin
            key_pressed = ((i / 3) % 2) == 0;
            @(negedge clk);
        end
        key_pressed = 1'b0;
        repeat (12) @(negedge clk);
        check("bounce_drop", n_drop, 1);
        check("bounce_q", q_count, 0);

        press(4'h2, 20, 0);
        check("up_q", q_count, 1);
        check("up_drop", n_drop, 1);
        do_tick("up_tick", 1, 0, 0);
        check("up_upd_cnt", n_upd, 1);

        press(4'hF, 6, 0);
        check("rs1_cnt", n_rst, 1);
        check("rs1_dir", dir, 3);

        press(4'h4, 6, 0);
        check("rev_drop", n_drop, 2);
        check("rev_q", q_count, 0);
        press(4'h2, 6, 0);
        press(4'h4, 6, 0);
        check("two_q", q_count, 2);
        do_tick("t1", 1, 0, 1);
        do_tick("t2", 1, 2, 0);

        press(4'h2, 6, 0);
        press(4'h4, 6, 0);
        check("full_q", q_count, 2);
        press(4'h8, 6, 0);
        check("full_drop", n_drop, 3);
        check("full_q2", q_count, 2);
        press(4'h8, 6, 4);
        check("co_q", q_count, 2);
        check("co_dir", dir, 0);
        check("co_drop", n_drop, 3);
        check("co_upd_cnt", n_upd, 4);

        press(4'h5, 6, 0);
        check("pause_on", paused, 1);
        do_tick("ptick", 0, 0, 2);
        press(4'h5, 6, 0);
        check("pause_off", paused, 0);
        do_tick("utick", 1, 2, 1);

        press(4'h4, 6, 0);
        check("pre_rs_q", q_count, 2);
        press(4'hF, 6, 0);
        check("rs2_cnt", n_rst, 2);
        check("rs2_q", q_count, 0);
        check("rs2_dir", dir, 3);
        check("rs2_paused", paused, 0);

        // reset in the middle of a confirm window
        @(negedge clk);
        key_val     = 4'h2;
        key_pressed = 1'b1;
        repeat (2) @(negedge clk);
        rst         = 1'b1;
        key_pressed = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_rst_q", q_count, 0);
        check("mid_rst_dir", dir, 3);

        @(negedge clk);
        key_pressed = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("requal_early", q_count, 0);
        repeat (3) @(negedge clk);
        key_pressed = 1'b0;
        repeat (12) @(negedge clk);
        check("requal_q", q_count, 1);
        check("requal_dir", dir, 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
